multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
Multicycle RISC-V control unit: Moore FSM plus combinational instruction decoders. It sequences fetch, decode, execute, memory and writeback over several cycles, and drives the shared-ALU/shared-memory datapath. It generalises the single-cycle controller in four ways: parametrised ALU-control width, full conditional-branch set, memory ready handshake, and per-state datapath enables.

Parameters:
ALUC_W, 3, ALUControl width. 3 = add/sub/and/or/slt. 4 = adds xor/sll/srl/sra/sltu.
FULL_BRANCH, 1, 1 = beq/bne/blt/bge/bltu/bgeu. 0 = beq only; other funct3 are never taken.

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
op  in  7  instruction opcode, from IR
funct3  in  3  instruction funct3
funct7b5  in  1  instruction bit 30
Zero  in  1  ALU result == 0
Lt  in  1  signed SrcA < SrcB
Ltu  in  1  unsigned SrcA < SrcB
mem_ready  in  1  memory completes access this cycle
PCWrite  out  1  PC register enable
AdrSrc  out  1  0 = PC, 1 = ALUOut to memory address
MemWrite  out  1  memory write strobe
IRWrite  out  1  IR/OldPC enable
ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
ALUSrcA  out  2  00 PC, 01 OldPC, 10 RD1
ALUSrcB  out  2  00 RD2, 01 ImmExt, 10 constant 4
ImmSrc  out  2  00 I, 01 S, 10 B, 11 J
ALUControl  out  ALUC_W  ALU operation
RegWrite  out  1  register file write enable
illegal  out  1  sticky illegal-opcode flag (feature only; tied 0 otherwise)

Behaviour:
- Async reset: state = FETCH. All strobes are 0 while reset is held. First fetch occurs in the first cycle after deassertion.
- Outputs are Moore from state. Exceptions: PCWrite and IRWrite also depend on mem_ready and branch outcome; ImmSrc and ALUControl are decoded combinationally from op/funct.
- Internal PCUpdate and Branch signals: PCWrite = PCUpdate | (Branch & taken).
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite = PCUpdate = mem_ready. Stay in FETCH until mem_ready=1, then go to DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00; computes branch/jump target. Next state:
  - op 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1101111 -> JAL
  - 1100011 -> BRANCH
  - any other -> FETCH (NOP)
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next: MEMREAD (lw) or MEMWRITE (sw).
- MEMREAD: AdrSrc=1, ResultSrc=00. Hold until mem_ready, then MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1 -> FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1, held high until mem_ready -> FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10 -> ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10 -> ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1 -> FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1 -> FETCH. taken by funct3:
  - 000 Zero; 001 !Zero
  - 100 Lt; 101 !Lt
  - 110 Ltu; 111 !Ltu
  - others 0
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1 -> ALUWB.
- ALU decode:
  - ALUOp 00 -> add; 01 -> sub.
  - ALUOp 10 by funct3: 000 add, or sub if funct7b5 & op[5]; 010 slt; 110 or; 111 and.
  - ALUC_W=4 also decodes: 100 xor, 001 sll, 101 srl/sra (funct7b5), 011 sltu.
  - Unsupported funct3 -> add.
- Reset asserted mid-instruction aborts immediately; no strobe may glitch high during reset.

Optional Feature:
ILLEGAL_TRAP_EN.
- Defined: an undecodable opcode in DECODE enters state TRAP. TRAP drives all strobes 0, sets illegal=1 and holds until reset.
- Undefined: an undecodable opcode returns to FETCH; illegal is tied 0; TRAP state is absent.

Decomposition:
Package mc_ctrl_pkg holds:
- state enum
- opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_B)
- ALUControl encodings: 0000 add, 0001 sub, 0010 and, 0011 or, 0101 slt, 0100 xor, 0110 sll, 0111 srl, 1000 sra, 1001 sltu (3-bit uses low bits)
- ImmSrc/ResultSrc/ALUSrc encodings

Sub-module aludec (ALUOp, funct3, funct7b5, op5 -> ALUControl), parametrised by ALUC_W.

Test Plan:
1. Reset mid-MEMWRITE, mem_ready=0 -> MemWrite drops to 0 asynchronously; FETCH strobes appear in the cycle after release.
2. lw (op 0000011), mem_ready held 0 for 3 cycles in both FETCH and MEMREAD -> 5 + 6 = 11 cycles total; RegWrite pulses exactly once, in MEMWB.
3. sub R-type (funct3 000, funct7b5 1) -> ALUControl=0001 in EXECUTER; RegWrite=1 in ALUWB; 4 cycles with mem_ready=1.
4. bne, FULL_BRANCH=1: Zero=0 -> PCWrite=1 in BRANCH; Zero=1 -> PCWrite=0. With FULL_BRANCH=0, bne is never taken.
5. jal -> PCWrite=1 in JAL, RegWrite=1 in ALUWB, ImmSrc=11 throughout.
6. op 1111111 -> with ILLEGAL_TRAP_EN: illegal=1 sticky and no strobes until reset; without it: returns to FETCH, illegal=0.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared types and encodings for the multicycle RISC-V controller.
//   - state_t  : FSM states. S_TRAP exists only when ILLEGAL_TRAP_EN is defined.
//   - opcodes  : OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_B
//   - ALU_*    : ALUControl encodings (4-bit; the 3-bit build uses the low bits)
//   - ctrl_t   : registered Moore control word, built by moore_outs()
// Optional feature macro: ILLEGAL_TRAP_EN (adds S_TRAP and the illegal flag).
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
`ifdef ILLEGAL_TRAP_EN
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
`else
        S_JAL      = 4'd10
`endif
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_B   = 7'b1100011;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLL  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    typedef struct packed {
        logic       adr_src;
        logic       mem_write;
        logic       reg_write;
        logic       branch;
        logic       pc_update;
`ifdef ILLEGAL_TRAP_EN
        logic       illegal;
`endif
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    // Moore control word for a state. Fields not listed stay 0.
    // pc_update here only covers JAL; the FETCH increment depends on mem_ready
    // and is formed combinationally in the top.
    function automatic ctrl_t moore_outs(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.alu_src_a  = SRCA_PC;
                c.alu_src_b  = SRCB_FOUR;
                c.alu_op     = ALUOP_ADD;
                c.result_src = RES_ALURESULT;
            end
            S_DECODE: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                c.alu_src_a = SRCA_RD1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_ADD;
            end
            S_MEMREAD: begin
                c.adr_src    = 1'b1;
                c.result_src = RES_ALUOUT;
            end
            S_MEMWB: begin
                c.result_src = RES_DATA;
                c.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                c.adr_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            S_EXECUTER: begin
                c.alu_src_a = SRCA_RD1;
                c.alu_src_b = SRCB_RD2;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                c.alu_src_a = SRCA_RD1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                c.result_src = RES_ALUOUT;
                c.reg_write  = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a  = SRCA_RD1;
                c.alu_src_b  = SRCB_RD2;
                c.alu_op     = ALUOP_SUB;
                c.result_src = RES_ALUOUT;
                c.branch     = 1'b1;
            end
            S_JAL: begin
                c.alu_src_a  = SRCA_OLDPC;
                c.alu_src_b  = SRCB_FOUR;
                c.alu_op     = ALUOP_ADD;
                c.result_src = RES_ALUOUT;
                c.pc_update  = 1'b1;
            end
`ifdef ILLEGAL_TRAP_EN
            S_TRAP: begin
                c.illegal = 1'b1;
            end
`endif
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/aludec.sv
// aludec: ALU operation decoder.
//   i_alu_op      : 00 add, 01 sub, 10 decode from funct3/funct7b5
//   i_funct3      : instruction funct3
//   i_funct7b5    : instruction bit 30
//   i_op5         : opcode bit 5 (distinguishes R-type sub from addi)
//   o_alu_control : ALU operation, ALUC_W bits (3 or 4)
// With ALUC_W=3 only add/sub/and/or/slt exist; everything else decodes to add.
module aludec
    import mc_ctrl_pkg::*;
#(
    parameter int ALUC_W = 3
) (
    input  logic [1:0]        i_alu_op,
    input  logic [2:0]        i_funct3,
    input  logic              i_funct7b5,
    input  logic              i_op5,
    output logic [ALUC_W-1:0] o_alu_control
);

    always_comb begin
        o_alu_control = ALU_ADD[ALUC_W-1:0];
        case (i_alu_op)
            ALUOP_ADD: o_alu_control = ALU_ADD[ALUC_W-1:0];
            ALUOP_SUB: o_alu_control = ALU_SUB[ALUC_W-1:0];
            ALUOP_FUNCT: begin
                case (i_funct3)
                    3'b000: begin
                        // funct7b5 is an immediate bit for addi, so only R-type subtracts
                        if (i_funct7b5 && i_op5) o_alu_control = ALU_SUB[ALUC_W-1:0];
                    end
                    3'b010: o_alu_control = ALU_SLT[ALUC_W-1:0];
                    3'b110: o_alu_control = ALU_OR[ALUC_W-1:0];
                    3'b111: o_alu_control = ALU_AND[ALUC_W-1:0];
                    3'b100: if (ALUC_W >= 4) o_alu_control = ALU_XOR[ALUC_W-1:0];
                    3'b001: if (ALUC_W >= 4) o_alu_control = ALU_SLL[ALUC_W-1:0];
                    3'b101: begin
                        if (ALUC_W >= 4) begin
                            o_alu_control = i_funct7b5 ? ALU_SRA[ALUC_W-1:0]
                                                       : ALU_SRL[ALUC_W-1:0];
                        end
                    end
                    3'b011: if (ALUC_W >= 4) o_alu_control = ALU_SLTU[ALUC_W-1:0];
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM + decoders for a multicycle RISC-V datapath.
// Inputs : clk, reset (async, active high), op/funct3/funct7b5 from IR,
//          Zero/Lt/Ltu ALU flags, mem_ready memory completion.
// Outputs: PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
//          ImmSrc, ALUControl, RegWrite, illegal, o_dbg_state (current state).
// Parameters: ALUC_W (3 or 4), FULL_BRANCH (1 = full branch set, 0 = beq only).
// Optional feature macro: ILLEGAL_TRAP_EN (undecodable opcode -> sticky TRAP).
//
// Memory handshake: a memory access is presented by the state (FETCH, MEMREAD,
// MEMWRITE) and completes in the cycle mem_ready=1; the FSM holds the state
// and its strobes unchanged until then and leaves on the following edge.
module multicycle_controller
    import mc_ctrl_pkg::*;
#(
    parameter int ALUC_W      = 3,
    parameter bit FULL_BRANCH = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [6:0]        op,
    input  logic [2:0]        funct3,
    input  logic              funct7b5,
    input  logic              Zero,
    input  logic              Lt,
    input  logic              Ltu,
    input  logic              mem_ready,
    output logic              PCWrite,
    output logic              AdrSrc,
    output logic              MemWrite,
    output logic              IRWrite,
    output logic [1:0]        ResultSrc,
    output logic [1:0]        ALUSrcA,
    output logic [1:0]        ALUSrcB,
    output logic [1:0]        ImmSrc,
    output logic [ALUC_W-1:0] ALUControl,
    output logic              RegWrite,
    output logic              illegal,
    output state_t            o_dbg_state
);

    state_t r_state;
    ctrl_t  r_ctrl;
    state_t w_next_state;
    logic   w_taken;
    logic   w_fetch_go;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_FETCH:    w_next_state = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: w_next_state = S_MEMADR;
                    OP_R:         w_next_state = S_EXECUTER;
                    OP_I:         w_next_state = S_EXECUTEI;
                    OP_JAL:       w_next_state = S_JAL;
                    OP_B:         w_next_state = S_BRANCH;
`ifdef ILLEGAL_TRAP_EN
                    default:      w_next_state = S_TRAP;
`else
                    default:      w_next_state = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   w_next_state = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  w_next_state = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    w_next_state = S_FETCH;
            S_MEMWRITE: w_next_state = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECUTER: w_next_state = S_ALUWB;
            S_EXECUTEI: w_next_state = S_ALUWB;
            S_ALUWB:    w_next_state = S_FETCH;
            S_BRANCH:   w_next_state = S_FETCH;
            S_JAL:      w_next_state = S_ALUWB;
`ifdef ILLEGAL_TRAP_EN
            S_TRAP:     w_next_state = S_TRAP;
`endif
            default:    w_next_state = S_FETCH;
        endcase
    end

    // The control word is registered from the next state, so every Moore
    // output is a flop output and clears asynchronously with reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_ctrl  <= moore_outs(S_FETCH);
        end else begin
            r_state <= w_next_state;
            r_ctrl  <= moore_outs(w_next_state);
        end
    end

    always_comb begin
        w_taken = 1'b0;
        if (funct3 == 3'b000) begin
            w_taken = Zero;
        end else if (FULL_BRANCH) begin
            case (funct3)
                3'b001:  w_taken = ~Zero;
                3'b100:  w_taken = Lt;
                3'b101:  w_taken = ~Lt;
                3'b110:  w_taken = Ltu;
                3'b111:  w_taken = ~Ltu;
                default: w_taken = 1'b0;
            endcase
        end
    end

    always_comb begin
        case (op)
            OP_SW:   ImmSrc = IMM_S;
            OP_B:    ImmSrc = IMM_B;
            OP_JAL:  ImmSrc = IMM_J;
            default: ImmSrc = IMM_I;
        endcase
    end

    aludec #(
        .ALUC_W(ALUC_W)
    ) u_aludec (
        .i_alu_op      (r_ctrl.alu_op),
        .i_funct3      (funct3),
        .i_funct7b5    (funct7b5),
        .i_op5         (op[5]),
        .o_alu_control (ALUControl)
    );

    // The state sits at FETCH during reset, so the mem_ready-driven strobes
    // are explicitly masked by reset to keep them low while it is held.
    assign w_fetch_go = (r_state == S_FETCH) & mem_ready;
    assign IRWrite    = ~reset & w_fetch_go;
    assign PCWrite    = ~reset & (w_fetch_go | r_ctrl.pc_update | (r_ctrl.branch & w_taken));

    assign AdrSrc      = r_ctrl.adr_src;
    assign MemWrite    = r_ctrl.mem_write;
    assign RegWrite    = r_ctrl.reg_write;
    assign ResultSrc   = r_ctrl.result_src;
    assign ALUSrcA     = r_ctrl.alu_src_a;
    assign ALUSrcB     = r_ctrl.alu_src_b;
    assign o_dbg_state = r_state;

`ifdef ILLEGAL_TRAP_EN
    assign illegal = r_ctrl.illegal;
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
`timescale 1ns / 1ps
module tb_multicycle_controller;
    import mc_ctrl_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #20 clk = ~clk;

    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5, Zero, Lt, Ltu, mem_ready;

    // DUT a: default build (ALUC_W=3, FULL_BRANCH=1)
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    state_t     dbg_state;

    // DUT b: ALUC_W=4, FULL_BRANCH=0
    logic       b_PCWrite, b_AdrSrc, b_MemWrite, b_IRWrite, b_RegWrite, b_illegal;
    logic [1:0] b_ResultSrc, b_ALUSrcA, b_ALUSrcB, b_ImmSrc;
    logic [3:0] b_ALUControl;
    state_t     b_dbg_state;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .Lt(Lt), .Ltu(Ltu), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .ALUControl(ALUControl), .RegWrite(RegWrite), .illegal(illegal),
        .o_dbg_state(dbg_state)
    );

    multicycle_controller #(.ALUC_W(4), .FULL_BRANCH(1'b0)) dut_b (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .Lt(Lt), .Ltu(Ltu), .mem_ready(mem_ready),
        .PCWrite(b_PCWrite), .AdrSrc(b_AdrSrc), .MemWrite(b_MemWrite), .IRWrite(b_IRWrite),
        .ResultSrc(b_ResultSrc), .ALUSrcA(b_ALUSrcA), .ALUSrcB(b_ALUSrcB), .ImmSrc(b_ImmSrc),
        .ALUControl(b_ALUControl), .RegWrite(b_RegWrite), .illegal(b_illegal),
        .o_dbg_state(b_dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [3:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // cyc leaves us 1ns after the active edge; checks are made 2ns later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        op = o;
        funct3 = f3;
        funct7b5 = f7;
    endtask

    // funct3, funct7b5, expected 3-bit code, expected 4-bit code (R-type, ALUOp=10)
    int alu_tab[10][4] = '{
        '{0, 1, 1, 1}, '{0, 0, 0, 0}, '{2, 0, 5, 5}, '{6, 0, 3, 3}, '{7, 0, 2, 2},
        '{4, 0, 0, 4}, '{1, 0, 0, 6}, '{5, 0, 0, 7}, '{5, 1, 0, 8}, '{3, 0, 0, 9}
    };

    // funct3, Zero, Lt, Ltu, expected PCWrite (full set), expected PCWrite (beq only)
    int br_tab[10][6] = '{
        '{1, 0, 0, 0, 1, 0}, '{1, 1, 0, 0, 0, 0}, '{0, 1, 0, 0, 1, 1}, '{0, 0, 0, 0, 0, 0},
        '{4, 0, 1, 0, 1, 0}, '{5, 0, 1, 0, 0, 0}, '{6, 0, 0, 1, 1, 0}, '{7, 0, 0, 0, 1, 0},
        '{2, 1, 1, 1, 0, 0}, '{5, 0, 0, 0, 1, 0}
    };

    task automatic t_reset_state();
        mem_ready = 1'b1;
        set_instr(OP_R, 3'b000, 1'b0);
        #1 reset = 1'b1;
        @(posedge clk);
        #3;
        check("rst_state", 32'(dbg_state), 32'(S_FETCH));
        check("rst_irwrite", 32'(IRWrite), 0);
        check("rst_pcwrite", 32'(PCWrite), 0);
        check("rst_memwrite", 32'(MemWrite), 0);
        check("rst_regwrite", 32'(RegWrite), 0);
        cyc();
        reset = 1'b0;
        #2;
        check("first_fetch_irwrite", 32'(IRWrite), 1);
        check("first_fetch_srcb", 32'(ALUSrcB), 2);
    endtask

    task automatic t_reset_mid_write();
        set_instr(OP_SW, 3'b010, 1'b0);
        mem_ready = 1'b1;
        #2 check("sw_fetch_irwrite", 32'(IRWrite), 1);
        cyc(); mem_ready = 1'b0;
        #2 check("sw_decode_state", 32'(dbg_state), 32'(S_DECODE));
        check("sw_immsrc", 32'(ImmSrc), 1);
        cyc();
        #2 check("sw_memadr_srca", 32'(ALUSrcA), 2);
        cyc();
        #2 check("sw_memwrite", 32'(MemWrite), 1);
        check("sw_adrsrc", 32'(AdrSrc), 1);
        cyc();
        #2 check("sw_memwrite_hold", 32'(MemWrite), 1);
        mem_ready = 1'b1;
        reset = 1'b1;
        #1 check("sw_rst_memwrite", 32'(MemWrite), 0);
        check("sw_rst_state", 32'(dbg_state), 32'(S_FETCH));
        check("sw_rst_irwrite", 32'(IRWrite), 0);
        cyc();
        reset = 1'b0;
        #2 check("sw_rel_irwrite", 32'(IRWrite), 1);
        check("sw_rel_pcwrite", 32'(PCWrite), 1);
        check("sw_rel_resultsrc", 32'(ResultSrc), 2);
        check("sw_rel_adrsrc", 32'(AdrSrc), 0);
    endtask

    task automatic t_lw();
        int rw_cnt = 0;
        set_instr(OP_LW, 3'b010, 1'b0);
        for (int i = 0; i < 4; i++) exp_q.push_back(S_FETCH);
        exp_q.push_back(S_DECODE);
        exp_q.push_back(S_MEMADR);
        for (int i = 0; i < 4; i++) exp_q.push_back(S_MEMREAD);
        exp_q.push_back(S_MEMWB);
        for (int i = 0; i < 11; i++) begin
            mem_ready = (i == 3 || i == 9);
            #2;
            check("lw_state", 32'(dbg_state), 32'(exp_q.pop_front()));
            if (RegWrite) rw_cnt++;
            if (i == 2) check("lw_fetch_wait_irwrite", 32'(IRWrite), 0);
            if (i == 6) check("lw_adrsrc", 32'(AdrSrc), 1);
            if (i == 10) begin
                check("lw_memwb_result", 32'(ResultSrc), 1);
                check("lw_memwb_regwrite", 32'(RegWrite), 1);
            end
            cyc();
        end
        #2;
        check("lw_back_fetch", 32'(dbg_state), 32'(S_FETCH));
        check("lw_regwrite_pulses", 32'(rw_cnt), 1);
    endtask

    task automatic t_sub();
        set_instr(OP_R, 3'b000, 1'b1);
        mem_ready = 1'b1;
        #2 check("sub_fetch_aluc", 32'(ALUControl), 0);
        cyc();
        #2 check("sub_decode_state", 32'(dbg_state), 32'(S_DECODE));
        cyc();
        #2 check("sub_exec_aluc", 32'(ALUControl), 1);
        check("sub_exec_aluc_w4", 32'(b_ALUControl), 1);
        check("sub_exec_srcb", 32'(ALUSrcB), 0);
        for (int i = 0; i < 10; i++) begin
            funct3 = 3'(alu_tab[i][0]);
            funct7b5 = alu_tab[i][1][0];
            #1;
            check($sformatf("alu3_f%0d", i), 32'(ALUControl), alu_tab[i][2]);
            check($sformatf("alu4_f%0d", i), 32'(b_ALUControl), alu_tab[i][3]);
        end
        set_instr(OP_R, 3'b000, 1'b1);
        cyc();
        #2 check("sub_aluwb_regwrite", 32'(RegWrite), 1);
        check("sub_aluwb_result", 32'(ResultSrc), 0);
        cyc();
        #2 check("sub_done_state", 32'(dbg_state), 32'(S_FETCH));
    endtask

    task automatic t_addi();
        set_instr(OP_I, 3'b000, 1'b1);
        mem_ready = 1'b1;
        cyc();
        cyc();
        #2 check("addi_state", 32'(dbg_state), 32'(S_EXECUTEI));
        check("addi_aluc", 32'(ALUControl), 0);
        check("addi_srcb", 32'(ALUSrcB), 1);
    endtask

    task automatic t_branch();
        set_instr(OP_B, 3'b001, 1'b0);
        mem_ready = 1'b1;
        Zero = 1'b0; Lt = 1'b0; Ltu = 1'b0;
        cyc();
        #2 check("br_decode_immsrc", 32'(ImmSrc), 2);
        check("br_decode_pcwrite", 32'(PCWrite), 0);
        cyc();
        #2 check("br_state", 32'(dbg_state), 32'(S_BRANCH));
        check("br_aluc", 32'(ALUControl), 1);
        check("br_aluc_w4", 32'(b_ALUControl), 1);
        for (int i = 0; i < 10; i++) begin
            funct3 = 3'(br_tab[i][0]);
            Zero = br_tab[i][1][0];
            Lt   = br_tab[i][2][0];
            Ltu  = br_tab[i][3][0];
            #1;
            check($sformatf("br_full_%0d", i), 32'(PCWrite), br_tab[i][4]);
            check($sformatf("br_beq_only_%0d", i), 32'(b_PCWrite), br_tab[i][5]);
        end
        cyc();
        #2 check("br_done_state", 32'(dbg_state), 32'(S_FETCH));
    endtask

    task automatic t_jal();
        set_instr(OP_JAL, 3'b000, 1'b0);
        mem_ready = 1'b1;
        #2 check("jal_fetch_immsrc", 32'(ImmSrc), 3);
        cyc();
        #2 check("jal_decode_srca", 32'(ALUSrcA), 1);
        cyc();
        #2 check("jal_pcwrite", 32'(PCWrite), 1);
        check("jal_srcb", 32'(ALUSrcB), 2);
        check("jal_immsrc", 32'(ImmSrc), 3);
        cyc();
        #2 check("jal_aluwb_regwrite", 32'(RegWrite), 1);
        check("jal_aluwb_pcwrite", 32'(PCWrite), 0);
        check("jal_aluwb_immsrc", 32'(ImmSrc), 3);
        cyc();
        #2 check("jal_done_state", 32'(dbg_state), 32'(S_FETCH));
    endtask

    task automatic t_illegal();
        set_instr(7'b1111111, 3'b000, 1'b0);
        mem_ready = 1'b1;
        cyc();
        #2 check("ill_decode_illegal", 32'(illegal), 0);
        cyc();
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 3; i++) begin
            #2;
            check("ill_trap_state", 32'(dbg_state), 32'(S_TRAP));
            check("ill_flag", 32'(illegal), 1);
            check("ill_strobes", 32'({PCWrite, IRWrite, MemWrite, RegWrite}), 0);
            cyc();
        end
        do_reset();
        #2 check("ill_cleared", 32'(illegal), 0);
`else
        #2 check("ill_back_fetch", 32'(dbg_state), 32'(S_FETCH));
        check("ill_flag_tied", 32'(illegal), 0);
        check("ill_fetch_irwrite", 32'(IRWrite), 1);
`endif
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset = 1'b0;
        Zero = 1'b0; Lt = 1'b0; Ltu = 1'b0;
        t_reset_state();
        do_reset();
        t_reset_mid_write();
        do_reset();
        t_lw();
        do_reset();
        t_sub();
        do_reset();
        t_addi();
        do_reset();
        t_branch();
        do_reset();
        t_jal();
        do_reset();
        t_illegal();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
